// File: rtl/taxi_fare_meter.sv
// taxi_fare_meter
// Fare accumulator for the taxi meter. A ride starts at a base fare. After
// that the fare grows with wheel-distance pulses once the distance paid by the
// base fare is used up. It also grows with waiting time while the cab stands
// still. The fare saturates at a ceiling that a 4-digit display can show.
// Commands come from the panel logic as one-cycle pulses. When several arrive
// in the same cycle, clear beats stop and stop beats start.

module taxi_fare_meter #(
    parameter int BASE_FARE = 30,   // fare loaded on ride start
    parameter int BASE_DIST = 20,   // distance pulses included in the base fare
    parameter int DIST_STEP = 5,    // distance pulses per fare step
    parameter int WAIT_SEC  = 10,   // idle seconds per fare step
    parameter int FARE_STEP = 1,    // size of one fare step
    parameter int FARE_MAX  = 999   // saturation ceiling
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       dist_pulse,
    input  logic       sec_tick,
    output logic [9:0] fare,
    output logic       meter_on,
    output logic       fare_hold,
    output logic       fare_upd,
    output logic       saturated
);

    // Counter widths. A counter that only ever holds 0 still gets one bit.
    localparam int BW = $clog2(BASE_DIST + 1);
    localparam int SW = (DIST_STEP > 1) ? $clog2(DIST_STEP) : 1;
    localparam int WW = (WAIT_SEC > 1) ? $clog2(WAIT_SEC) : 1;

    localparam logic [BW-1:0] BASE_DIST_C = BW'(BASE_DIST);
    localparam logic [SW-1:0] STEP_LAST   = SW'(DIST_STEP - 1);
    localparam logic [WW-1:0] WAIT_LAST   = WW'(WAIT_SEC - 1);
    localparam logic [9:0]    BASE_FARE_C = 10'(BASE_FARE);
    localparam logic [9:0]    FARE_MAX_C  = 10'(FARE_MAX);
    localparam logic [10:0]   FARE_STEP_W = 11'(FARE_STEP);
    localparam logic [10:0]   FARE_MAX_W  = 11'(FARE_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t        state;
    logic [BW-1:0] base_cnt;   // distance pulses consumed by the base fare
    logic [SW-1:0] step_cnt;   // distance pulses toward the next step
    logic [WW-1:0] wait_cnt;   // consecutive motionless seconds

    logic [BW-1:0] base_nxt;
    logic [SW-1:0] step_nxt;
    logic [WW-1:0] wait_nxt;
    logic          inc_req;    // this cycle earns one fare step
    logic [10:0]   fare_sum;   // one bit wider, so a carry past 1023 is not lost
    logic          sat_hit;
    logic [9:0]    fare_inc;

    // Next counter values and increment request, assuming the meter is running.
    // The sequential block decides whether to commit them.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        base_nxt = base_cnt;
        step_nxt = step_cnt;
        wait_nxt = wait_cnt;
        inc_req  = 1'b0;
        if (dist_pulse) begin
            // Motion always restarts the waiting count. A tick in the same
            // cycle is discarded.
            wait_nxt = '0;
            if (base_cnt != BASE_DIST_C) begin
                base_nxt = base_cnt + 1'b1;
            end else if (step_cnt == STEP_LAST) begin
                step_nxt = '0;
                inc_req  = 1'b1;
            end else begin
                step_nxt = step_cnt + 1'b1;
            end
        end else if (sec_tick) begin
            if (wait_cnt == WAIT_LAST) begin
                wait_nxt = '0;
                inc_req  = 1'b1;
            end else begin
                wait_nxt = wait_cnt + 1'b1;
            end
        end
    end

    // Saturating fare increment.
    always_comb begin
        fare_sum = {1'b0, fare} + FARE_STEP_W;
        sat_hit  = (fare_sum >= FARE_MAX_W);
        fare_inc = sat_hit ? FARE_MAX_C : fare_sum[9:0];
    end

    // Ride FSM with the fare register, the counters and the registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments, so every register
        // in this block samples the values from before the clock edge.
        if (!rst_n) begin
            state     <= S_IDLE;
            fare      <= '0;
            base_cnt  <= '0;
            step_cnt  <= '0;
            wait_cnt  <= '0;
            meter_on  <= 1'b0;
            fare_hold <= 1'b0;
            fare_upd  <= 1'b0;
            saturated <= 1'b0;
        end else begin
            fare_upd <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A start that arrives together with a higher-priority command is dropped.
                    if (start && !stop && !clear) begin
                        state     <= S_RUN;
                        meter_on  <= 1'b1;
                        fare_hold <= 1'b0;
                        fare      <= BASE_FARE_C;
                        fare_upd  <= 1'b1;
                        saturated <= (BASE_FARE_C == FARE_MAX_C);
                        base_cnt  <= '0;
                        step_cnt  <= '0;
                        wait_cnt  <= '0;
                    end
                end

                S_RUN: begin
                    if (clear) begin
                        state     <= S_IDLE;
                        meter_on  <= 1'b0;
                        fare_hold <= 1'b0;
                        fare      <= '0;
                        fare_upd  <= 1'b1;
                        saturated <= 1'b0;
                        base_cnt  <= '0;
                        step_cnt  <= '0;
                        wait_cnt  <= '0;
                    end else if (stop) begin
                        // Freeze. Motion or a tick in this cycle is not counted.
                        state     <= S_HOLD;
                        meter_on  <= 1'b0;
                        fare_hold <= 1'b1;
                    end else begin
                        // The counters keep running after saturation.
                        base_cnt <= base_nxt;
                        step_cnt <= step_nxt;
                        wait_cnt <= wait_nxt;
                        if (inc_req) begin
                            fare <= fare_inc;
                            if (fare_inc != fare) begin
                                fare_upd <= 1'b1;
                            end
                            if (sat_hit) begin
                                saturated <= 1'b1;
                            end
                        end
                    end
                end

                S_HOLD: begin
                    if (clear) begin
                        state     <= S_IDLE;
                        meter_on  <= 1'b0;
                        fare_hold <= 1'b0;
                        fare      <= '0;
                        fare_upd  <= 1'b1;
                        saturated <= 1'b0;
                        base_cnt  <= '0;
                        step_cnt  <= '0;
                        wait_cnt  <= '0;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    meter_on  <= 1'b0;
                    fare_hold <= 1'b0;
                    fare      <= '0;
                    saturated <= 1'b0;
                    base_cnt  <= '0;
                    step_cnt  <= '0;
                    wait_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/taxi_fare_meter.md
Name: taxi_fare_meter

Overview:
- Sequential fare accumulator for the taxi meter; produces the 10-bit binary fare that the downstream binary-to-BCD stage converts for the 4-digit display.
- Counts wheel-distance pulses and waiting seconds, applies base fare, distance and waiting increments, and saturates at a display-safe maximum.
- Controlled by start/stop/clear pulses from the panel logic.

Parameters:
- BASE_FARE, 30: fare loaded on ride start, in fare units. Legal range is 0..FARE_MAX.
- BASE_DIST, 20: distance pulses covered by the base fare. Must be ≥1.
- DIST_STEP, 5: distance pulses per FARE_STEP increment after base distance. Must be ≥1.
- WAIT_SEC, 10: consecutive sec_tick without a dist_pulse per FARE_STEP increment. Must be ≥1.
- FARE_STEP, 1: increment amount, in fare units.
- FARE_MAX, 999: saturation ceiling. Must be ≤999.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a ride.
- stop  input  1  one-cycle pulse; ends the ride and freezes the fare.
- clear  input  1  one-cycle pulse; returns to idle and zeroes the fare.
- dist_pulse  input  1  one-cycle pulse per distance unit, already synchronised.
- sec_tick  input  1  one-cycle pulse per second.
- fare  output  10  current fare, binary, registered.
- meter_on  output  1  high in RUN.
- fare_hold  output  1  high in HOLD.
- fare_upd  output  1  one-cycle pulse in the cycle fare takes a new value.
- saturated  output  1  high once fare has reached FARE_MAX in the current ride.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. fare=0, meter_on=0, fare_hold=0, fare_upd=0, saturated=0. All internal counters are 0.
- States: IDLE, RUN, HOLD. Command priority within a cycle is clear > stop > start.
- IDLE:
  - start → RUN. On that edge fare=BASE_FARE and fare_upd=1, so fare is visible 1 cycle after start.
  - If BASE_FARE=FARE_MAX, saturated=1.
  - stop and clear are ignored. dist_pulse and sec_tick are ignored.
- RUN:
  - clear → IDLE: fare=0, all counters=0, saturated=0, fare_upd=1.
  - stop → HOLD: fare is frozen and fare_upd=0. A dist_pulse or sec_tick in the same cycle is dropped.
  - start is ignored.
- Distance rule (RUN only):
  - base_cnt increments on each dist_pulse until it equals BASE_DIST, then holds.
  - A dist_pulse arriving when base_cnt==BASE_DIST advances step_cnt.
  - When step_cnt==DIST_STEP-1 and a dist_pulse arrives: step_cnt=0 and fare is incremented.
  - Result: the first increment occurs on pulse BASE_DIST+DIST_STEP.
- Waiting rule (RUN only, applies inside the base distance too):
  - wait_cnt counts sec_tick and is cleared by any dist_pulse.
  - When wait_cnt==WAIT_SEC-1 and a sec_tick arrives with no dist_pulse: wait_cnt=0 and fare is incremented.
- Simultaneous dist_pulse and sec_tick: the distance rule is applied, wait_cnt is cleared, and the tick is discarded. At most one increment occurs per cycle.
- Increment arithmetic:
  - Computed in 11 bits: sum = fare + FARE_STEP.
  - If sum ≥ FARE_MAX: fare=FARE_MAX and saturated=1.
  - fare_upd=1 only if fare actually changes; once fare is at FARE_MAX, further increments give no change and no pulse.
  - Counters keep running while saturated.
- HOLD:
  - fare, counters and saturated are frozen. dist_pulse, sec_tick, start and stop are ignored.
  - clear → IDLE as in RUN.
- Status outputs: meter_on and fare_hold are registered decodes of the state.
- Async reset asserted mid-ride forces the reset values immediately, independent of clk.

Test Plan:
- Reset, then start at cycle 5 → fare=0 through cycle 5. At cycle 6: fare=30, meter_on=1, fare_upd=1 for one cycle.
- In RUN, 20 dist_pulses → fare stays 30. Pulse 25 → fare=31. Pulse 30 → fare=32. fare_upd pulses exactly twice.
- Waiting: 10 sec_ticks with no motion → fare +1. Then 9 ticks, 1 dist_pulse, 9 ticks → no change. Finally dist_pulse and sec_tick in the same cycle while wait_cnt=9 → no wait increment.
- Saturation: after start, 4865 dist_pulses → fare=999, saturated=1. 10 more pulses and 20 ticks → fare=999, no fare_upd.
- Commands:
  - stop in RUN → fare_hold=1, fare frozen; pulses, ticks and start are ignored. clear → IDLE, fare=0, saturated=0.
  - stop+clear in the same cycle in RUN → IDLE.
  - stop/clear in IDLE → no effect.
- rst_n low for 1 ns mid-RUN with fare=45 between clock edges → fare=0 and meter_on=0 immediately. After release, fare stays 0 until start.
